// File: rtl/jstk_spi_master.sv
// rtl/jstk_spi_master.sv - PmodJSTK SPI master (mode 0) clocked from a divided SCLK_SRC level
// Exchanges an NBYTES frame per START and publishes it atomically on DOUT.
module jstk_spi_master #(
  parameter int NBYTES    = 5,
  parameter int GAP_TICKS = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SCLK_SRC,
  input  logic                  START,
  input  logic [7:0]            DIN,
  input  logic                  MISO,
  output logic                  SS,
  output logic                  SCLK,
  output logic                  MOSI,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [8*NBYTES-1:0]   DOUT
);

  localparam int FW = 8 * NBYTES;
  localparam int BW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_GAP,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic            src_q;
  logic            rise, fall;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [FW-1:0]   acc_q, acc_d;
  logic [FW-1:0]   dout_q, dout_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            ss_q, ss_d;
  logic            sclk_q, sclk_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  assign rise = SCLK_SRC & ~src_q;
  assign fall = ~SCLK_SRC & src_q;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    acc_d      = acc_q;
    dout_d     = dout_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ss_d       = ss_q;
    sclk_d     = sclk_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          tx_d       = DIN;
          ss_d       = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = S_SETUP;
        end
      end

      S_SETUP: begin
        if (fall) state_d = S_XFER;
      end

      S_XFER: begin
        if (rise) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[6:0], MISO};
        end else if (fall) begin
          sclk_d = 1'b0;
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = {tx_q[6:0], 1'b0};
          end else begin
            // MOSI is tx_q[7], so clearing tx parks the line low between bytes
            acc_d       = acc_q << 8;
            acc_d[7:0]  = rx_q;
            bit_cnt_d   = 3'd0;
            tx_d        = 8'h00;
            if (byte_cnt_q == BW'(NBYTES - 1)) begin
              state_d = S_FINISH;
            end else begin
              byte_cnt_d = byte_cnt_q + BW'(1);
              gap_cnt_d  = '0;
              state_d    = S_GAP;
            end
          end
        end
      end

      S_GAP: begin
        tx_d = 8'h00;
        if (fall) begin
          if (gap_cnt_q == GW'(GAP_TICKS - 1)) begin
            gap_cnt_d = '0;
            state_d   = S_XFER;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
      end

      S_FINISH: begin
        if (fall) begin
          ss_d    = 1'b1;
          dout_d  = acc_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      src_q      <= 1'b0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      acc_q      <= '0;
      dout_q     <= '0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      ss_q       <= 1'b1;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= SCLK_SRC;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      acc_q      <= acc_d;
      dout_q     <= dout_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ss_q       <= ss_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign SS   = ss_q;
  assign SCLK = sclk_q;
  assign MOSI = tx_q[7];
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign DOUT = dout_q;

endmodule

// File: tb/tb_jstk_spi_master.sv
// tb/tb_jstk_spi_master.sv - directed bench for jstk_spi_master (NBYTES=5 and NBYTES=1 instances)
module tb_jstk_spi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk_src = 1'b0;
  logic        start = 1'b0, start1 = 1'b0;
  logic        miso = 1'b0, miso1 = 1'b0;
  logic [7:0]  din = 8'h00, din1 = 8'h00;
  logic        ss, sclk, mosi, busy, done;
  logic        ss1, sclk1, mosi1, busy1, done1;
  logic [39:0] dout;
  logic [7:0]  dout1;

  logic [39:0] slave_frame = 40'h0;
  logic [7:0]  slave_byte1 = 8'h0;
  logic        src_run = 1'b0;
  int          src_div = 0;
  int          tests = 0, fails = 0;
  int          cyc = 0, done_cnt = 0;
  int          rise_cnt = 0, fr = 0, rise_cnt1 = 0, fr1 = 0;
  int          rise_t [0:63];
  logic [63:0] mosi_log = 64'h0;
  logic [7:0]  mosi_log1 = 8'h0;
  logic        prev_sclk = 1'b0, prev_sclk1 = 1'b0;

  jstk_spi_master dut (
    .CLK(clk), .RST_N(rst_n), .SCLK_SRC(sclk_src), .START(start), .DIN(din), .MISO(miso),
    .SS(ss), .SCLK(sclk), .MOSI(mosi), .BUSY(busy), .DONE(done), .DOUT(dout)
  );

  jstk_spi_master #(.NBYTES(1), .GAP_TICKS(2)) dut1 (
    .CLK(clk), .RST_N(rst_n), .SCLK_SRC(sclk_src), .START(start1), .DIN(din1), .MISO(miso1),
    .SS(ss1), .SCLK(sclk1), .MOSI(mosi1), .BUSY(busy1), .DONE(done1), .DOUT(dout1)
  );

  initial forever #5 clk = ~clk;

  // SCLK_SRC toggles every 10 CLK while running
  initial forever begin
    @(negedge clk);
    if (src_run) begin
      src_div = src_div + 1;
      if (src_div == 10) begin
        src_div  = 0;
        sclk_src = ~sclk_src;
      end
    end
  end

  // Slave models and SCLK-rise monitors for both instances
  initial forever begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (done) done_cnt = done_cnt + 1;
    if (ss) fr = 0;
    else if (sclk && !prev_sclk) begin
      if (fr < 64) rise_t[fr] = cyc;
      fr       = fr + 1;
      rise_cnt = rise_cnt + 1;
      mosi_log = {mosi_log[62:0], mosi};
    end
    prev_sclk = sclk;
    miso = (fr < 40) ? slave_frame[39-fr] : 1'b0;
    if (ss1) fr1 = 0;
    else if (sclk1 && !prev_sclk1) begin
      fr1       = fr1 + 1;
      rise_cnt1 = rise_cnt1 + 1;
      mosi_log1 = {mosi_log1[6:0], mosi1};
    end
    prev_sclk1 = sclk1;
    miso1 = (fr1 < 8) ? slave_byte1[7-fr1] : 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ((sel ? done1 : done) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  bit   ok, drop, hold;
  int   r0, d0;
  logic s_ss, s_sclk, s_mosi;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ss", ss, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dout", dout, 0);
    rst_n   = 1'b1;
    src_run = 1'b1;
    repeat (30) @(negedge clk);

    // Full frame with default parameters
    slave_frame = 40'h123456789A;
    din = 8'h83;
    r0 = rise_cnt;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ss", ss, 0);
    check("start_busy", busy, 1);
    check("start_mosi", mosi, 1);
    wait_done(1'b0, ok);
    check("frame_done", ok, 1);
    check("frame_dout", dout, 40'h123456789A);
    check("frame_rises", rise_cnt - r0, 40);
    check("frame_mosi", mosi_log[39:0], 40'h8300000000);
    check("frame_busy_at_done", busy, 0);
    check("frame_ss_at_done", ss, 1);
    check("gap_rise_spacing", rise_t[8] - rise_t[7], 60);
    check("bit_rise_spacing", rise_t[7] - rise_t[6], 20);
    @(negedge clk);
    check("done_one_cycle", done_cnt - d0, 1);

    // Reset abort during byte 2
    slave_frame = 40'hFFFFFFFFFF;
    din = 8'h3C;
    r0 = rise_cnt;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rise_cnt - r0 >= 20) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_reach_byte2", ok, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ss", ss, 1);
    check("abort_sclk", sclk, 0);
    check("abort_mosi", mosi, 0);
    check("abort_busy", busy, 0);
    check("abort_dout", dout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_idle_ss", ss, 1);

    // START held high: back-to-back frames
    slave_frame = 40'hA1B2C3D4E5;
    din = 8'h55;
    start = 1'b1;
    wait_done(1'b0, ok);
    check("held_done1", ok, 1);
    check("held_busy_low_at_done", busy, 0);
    @(negedge clk);
    check("held_restart_busy", busy, 1);
    check("held_restart_ss", ss, 0);
    r0 = rise_cnt;
    drop = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (!busy) drop = 1'b1;
    end
    start = 1'b0;
    check("held_done2", ok, 1);
    check("held_busy_never_drops", drop, 0);
    check("held_dout", dout, 40'hA1B2C3D4E5);
    check("held_rises", rise_cnt - r0, 40);
    check("held_mosi", mosi_log[39:0], 40'h5500000000);
    repeat (5) @(negedge clk);
    check("held_stops", busy, 0);

    // Stall SCLK_SRC after the 3rd rise of byte 0
    slave_frame = 40'h0F1E2D3C4B;
    din = 8'hC6;
    r0 = rise_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (rise_cnt - r0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    src_run = 1'b0;
    check("stall_reach", ok, 1);
    s_ss = ss;
    s_sclk = sclk;
    s_mosi = mosi;
    hold = 1'b1;
    repeat (500) begin
      @(negedge clk);
      if (ss !== s_ss || sclk !== s_sclk || mosi !== s_mosi) hold = 1'b0;
    end
    check("stall_hold", hold, 1);
    src_run = 1'b1;
    wait_done(1'b0, ok);
    check("stall_done", ok, 1);
    check("stall_dout", dout, 40'h0F1E2D3C4B);
    check("stall_mosi", mosi_log[39:0], 40'hC600000000);

    // Single-byte instance
    slave_byte1 = 8'h3C;
    din1 = 8'hA5;
    r0 = rise_cnt1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b1, ok);
    check("nb1_done", ok, 1);
    check("nb1_dout", dout1, 8'h3C);
    check("nb1_rises", rise_cnt1 - r0, 8);
    check("nb1_mosi", mosi_log1, 8'hA5);
    check("nb1_busy", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
